// File: rtl/l23_mgmt_ctrl_pkg.sv
// Shared types and constants for the L23 management command sequencer.
package l23_mgmt_ctrl_pkg;

    localparam int unsigned A0_W      = 13;
    localparam int unsigned D0_W      = 9;
    localparam int unsigned A12_W     = 4;
    localparam int unsigned D12_W     = 16;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned WORD_W    = 2 * BYTE_W;
    localparam int unsigned AH_W      = A0_W - BYTE_W;
    localparam int unsigned FRAME_LEN = 5;

    typedef enum logic [2:0] {
        S_SEL    = 3'd0,
        S_AH     = 3'd1,
        S_AL     = 3'd2,
        S_DH     = 3'd3,
        S_DL     = 3'd4,
        S_COMMIT = 3'd5,
        S_DRAIN  = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        TGT_MGMT0 = 2'd0,
        TGT_MGMT1 = 2'd1,
        TGT_MGMT2 = 2'd2
    } tgt_e;

    // Fully assembled write: address already trimmed to the widest port.
    typedef struct packed {
        tgt_e              tgt;
        logic [A0_W-1:0]   addr;
        logic [WORD_W-1:0] data;
    } wr_cmd_t;

    // A SEL byte names a real port only for codes 0..2.
    function automatic logic is_valid_tgt(input logic [BYTE_W-1:0] b);
        return b <= BYTE_W'(TGT_MGMT2);
    endfunction

endpackage

// File: rtl/l23_mgmt_ctrl_if.sv
// Command stream plus management write ports and status counters.
//  c_tdata/c_tvalid/c_tlast : byte stream from control plane
//  c_tready                 : byte accepted on tvalid&tready
//  writedata/writeaddr/we_* : three management write ports
//  cmd_cnt/err_cnt          : saturating good/bad frame counters
interface l23_mgmt_ctrl_if;
    import l23_mgmt_ctrl_pkg::*;

    logic [BYTE_W-1:0] c_tdata;
    logic              c_tvalid;
    logic              c_tlast;
    logic              c_tready;

    logic [D0_W-1:0]   writedata_mgmt_0;
    logic [A0_W-1:0]   writeaddr_mgmt_0;
    logic              we_mgmt_0;
    logic [D12_W-1:0]  writedata_mgmt_1;
    logic [A12_W-1:0]  writeaddr_mgmt_1;
    logic              we_mgmt_1;
    logic [D12_W-1:0]  writedata_mgmt_2;
    logic [A12_W-1:0]  writeaddr_mgmt_2;
    logic              we_mgmt_2;

    logic [CNT_W-1:0]  cmd_cnt;
    logic [CNT_W-1:0]  err_cnt;

    modport master (
        output c_tdata, c_tvalid, c_tlast,
        input  c_tready,
        input  writedata_mgmt_0, writeaddr_mgmt_0, we_mgmt_0,
        input  writedata_mgmt_1, writeaddr_mgmt_1, we_mgmt_1,
        input  writedata_mgmt_2, writeaddr_mgmt_2, we_mgmt_2,
        input  cmd_cnt, err_cnt
    );

    modport slave (
        input  c_tdata, c_tvalid, c_tlast,
        output c_tready,
        output writedata_mgmt_0, writeaddr_mgmt_0, we_mgmt_0,
        output writedata_mgmt_1, writeaddr_mgmt_1, we_mgmt_1,
        output writedata_mgmt_2, writeaddr_mgmt_2, we_mgmt_2,
        output cmd_cnt, err_cnt
    );

endinterface

// File: rtl/l23_mgmt_ctrl_sat_cnt.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
//  clk, rst_n : clock, async active-low reset
//  inc        : count one event this cycle
//  cnt        : current count
module l23_mgmt_ctrl_sat_cnt
    import l23_mgmt_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/l23_mgmt_ctrl.sv
// L23 management command sequencer: decodes 5-byte frames SEL,AH,AL,DH,DL
// from a byte stream and issues one-cycle writes on mgmt_0/1/2.
//  L23_clk, L23_rst : clock, async active-low reset
//  bus (slave)      : command stream in, write ports and counters out
module l23_mgmt_ctrl
    import l23_mgmt_ctrl_pkg::*;
(
    input  logic           L23_clk,
    input  logic           L23_rst,
    l23_mgmt_ctrl_if.slave bus
);

    state_e            state_q;
    state_e            state_n;
    logic              tready_q;
    logic              hs_c;
    logic              commit_c;
    logic              err_c;

    tgt_e              sel_q;
    logic [AH_W-1:0]   addr_hi_q;
    logic [BYTE_W-1:0] addr_lo_q;
    logic [BYTE_W-1:0] data_hi_q;
    wr_cmd_t           cmd_c;

    logic [D0_W-1:0]   wd0_q;
    logic [A0_W-1:0]   wa0_q;
    logic              we0_q;
    logic [D12_W-1:0]  wd1_q;
    logic [A12_W-1:0]  wa1_q;
    logic              we1_q;
    logic [D12_W-1:0]  wd2_q;
    logic [A12_W-1:0]  wa2_q;
    logic              we2_q;

    logic [CNT_W-1:0]  cmd_cnt;
    logic [CNT_W-1:0]  err_cnt;

    assign hs_c = bus.c_tvalid && tready_q;

    // Frame as it stands at the DL handshake; DL is still on the bus.
    assign cmd_c = '{tgt:  sel_q,
                     addr: {addr_hi_q, addr_lo_q},
                     data: {data_hi_q, bus.c_tdata}};

    // State register; ready is registered from the next state so COMMIT stalls the stream.
    always_ff @(posedge L23_clk or negedge L23_rst) begin
        if (!L23_rst) begin
            state_q  <= S_SEL;
            tready_q <= 1'b1;
        end else begin
            state_q  <= state_n;
            tready_q <= (state_n != S_COMMIT);
        end
    end

    // Next-state decode, commit and error events.
    always_comb begin
        state_n  = state_q;
        commit_c = 1'b0;
        err_c    = 1'b0;
        unique case (state_q)
            S_SEL: begin
                if (hs_c) begin
                    if (!is_valid_tgt(bus.c_tdata)) begin
                        err_c   = 1'b1;
                        state_n = bus.c_tlast ? S_SEL : S_DRAIN;
                    end else if (bus.c_tlast) begin
                        err_c   = 1'b1;
                        state_n = S_SEL;
                    end else begin
                        state_n = S_AH;
                    end
                end
            end
            S_AH: begin
                if (hs_c) begin
                    err_c   = bus.c_tlast;
                    state_n = bus.c_tlast ? S_SEL : S_AL;
                end
            end
            S_AL: begin
                if (hs_c) begin
                    err_c   = bus.c_tlast;
                    state_n = bus.c_tlast ? S_SEL : S_DH;
                end
            end
            S_DH: begin
                if (hs_c) begin
                    err_c   = bus.c_tlast;
                    state_n = bus.c_tlast ? S_SEL : S_DL;
                end
            end
            S_DL: begin
                if (hs_c) begin
                    commit_c = bus.c_tlast;
                    err_c    = !bus.c_tlast;
                    state_n  = bus.c_tlast ? S_COMMIT : S_DRAIN;
                end
            end
            S_COMMIT: begin
                state_n = S_SEL;
            end
            S_DRAIN: begin
                if (hs_c && bus.c_tlast) begin
                    state_n = S_SEL;
                end
            end
            default: begin
                state_n = S_SEL;
            end
        endcase
    end

    // Frame assembly and write-port registers; outputs are valid during COMMIT.
    always_ff @(posedge L23_clk or negedge L23_rst) begin
        if (!L23_rst) begin
            sel_q     <= TGT_MGMT0;
            addr_hi_q <= '0;
            addr_lo_q <= '0;
            data_hi_q <= '0;
            wd0_q     <= '0;
            wa0_q     <= '0;
            we0_q     <= 1'b0;
            wd1_q     <= '0;
            wa1_q     <= '0;
            we1_q     <= 1'b0;
            wd2_q     <= '0;
            wa2_q     <= '0;
            we2_q     <= 1'b0;
        end else begin
            we0_q <= 1'b0;
            we1_q <= 1'b0;
            we2_q <= 1'b0;
            if (hs_c) begin
                case (state_q)
                    S_SEL:   sel_q     <= tgt_e'(bus.c_tdata[1:0]);
                    S_AH:    addr_hi_q <= bus.c_tdata[AH_W-1:0];
                    S_AL:    addr_lo_q <= bus.c_tdata;
                    S_DH:    data_hi_q <= bus.c_tdata;
                    default: ;
                endcase
            end
            if (commit_c) begin
                case (cmd_c.tgt)
                    TGT_MGMT0: begin
                        wd0_q <= cmd_c.data[D0_W-1:0];
                        wa0_q <= cmd_c.addr;
                        we0_q <= 1'b1;
                    end
                    TGT_MGMT1: begin
                        wd1_q <= cmd_c.data;
                        wa1_q <= cmd_c.addr[A12_W-1:0];
                        we1_q <= 1'b1;
                    end
                    TGT_MGMT2: begin
                        wd2_q <= cmd_c.data;
                        wa2_q <= cmd_c.addr[A12_W-1:0];
                        we2_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    l23_mgmt_ctrl_sat_cnt u_cmd_cnt (
        .clk   (L23_clk),
        .rst_n (L23_rst),
        .inc   (commit_c),
        .cnt   (cmd_cnt)
    );

    l23_mgmt_ctrl_sat_cnt u_err_cnt (
        .clk   (L23_clk),
        .rst_n (L23_rst),
        .inc   (err_c),
        .cnt   (err_cnt)
    );

    assign bus.c_tready         = tready_q;
    assign bus.writedata_mgmt_0 = wd0_q;
    assign bus.writeaddr_mgmt_0 = wa0_q;
    assign bus.we_mgmt_0        = we0_q;
    assign bus.writedata_mgmt_1 = wd1_q;
    assign bus.writeaddr_mgmt_1 = wa1_q;
    assign bus.we_mgmt_1        = we1_q;
    assign bus.writedata_mgmt_2 = wd2_q;
    assign bus.writeaddr_mgmt_2 = wa2_q;
    assign bus.we_mgmt_2        = we2_q;
    assign bus.cmd_cnt          = cmd_cnt;
    assign bus.err_cnt          = err_cnt;

endmodule

// File: tb/tb_l23_mgmt_ctrl.sv
// Self-checking bench for l23_mgmt_ctrl: directed frames from the block's
// test list plus randomized frames against a frame-level reference model.
module tb_l23_mgmt_ctrl;
    import l23_mgmt_ctrl_pkg::*;

    typedef logic [7:0] bytes_t[$];
    typedef struct {
        int port;
        int addr;
        int data;
        int cyc;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    l23_mgmt_ctrl_if bus();

    l23_mgmt_ctrl dut (
        .L23_clk (clk),
        .L23_rst (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int passes = 0;

    // Cycle counter and write/ready monitor (sampled on the falling edge).
    int   cyc = 0;
    int   ready_bad = 0;
    int   ready_low = 0;
    int   multi_we = 0;
    int   we_n;
    obs_t obs_q[$];

    assign we_n = int'(bus.we_mgmt_0) + int'(bus.we_mgmt_1) + int'(bus.we_mgmt_2);

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.c_tready !== (we_n == 0)) ready_bad <= ready_bad + 1;
        if (bus.c_tready === 1'b0) ready_low <= ready_low + 1;
        if (we_n > 1) multi_we <= multi_we + 1;
        if (we_n == 1) begin
            obs_q.push_back('{port: bus.we_mgmt_0 ? 0 : (bus.we_mgmt_1 ? 1 : 2),
                              addr: bus.we_mgmt_0 ? int'(bus.writeaddr_mgmt_0) :
                                    (bus.we_mgmt_1 ? int'(bus.writeaddr_mgmt_1) : int'(bus.writeaddr_mgmt_2)),
                              data: bus.we_mgmt_0 ? int'(bus.writedata_mgmt_0) :
                                    (bus.we_mgmt_1 ? int'(bus.writedata_mgmt_1) : int'(bus.writedata_mgmt_2)),
                              cyc:  cyc});
        end
    end

    // Frame-level reference model.
    int exp_wa[3];
    int exp_wd[3];
    int exp_cmd;
    int exp_err;
    int exp_port;
    int exp_addr;
    int exp_data;
    int last_hs_cyc;

    task automatic model_reset();
        for (int p = 0; p < 3; p++) begin
            exp_wa[p] = 0;
            exp_wd[p] = 0;
        end
        exp_cmd = 0;
        exp_err = 0;
    endtask

    task automatic model_frame(input bytes_t fr, output bit good);
        int a;
        int d;
        good = (fr.size() == FRAME_LEN) && (fr[0] <= 8'd2);
        if (good) begin
            a        = {16'd0, fr[1], fr[2]};
            d        = {16'd0, fr[3], fr[4]};
            exp_port = int'(fr[0]);
            exp_addr = (exp_port == 0) ? a % 8192 : a % 16;
            exp_data = (exp_port == 0) ? d % 512  : d;
            exp_wa[exp_port] = exp_addr;
            exp_wd[exp_port] = exp_data;
            if (exp_cmd < 255) exp_cmd++;
        end else if (exp_err < 255) begin
            exp_err++;
        end
    endtask

    function automatic logic [31:0] get_wa(input int p);
        case (p)
            0:       return 32'(bus.writeaddr_mgmt_0);
            1:       return 32'(bus.writeaddr_mgmt_1);
            default: return 32'(bus.writeaddr_mgmt_2);
        endcase
    endfunction

    function automatic logic [31:0] get_wd(input int p);
        case (p)
            0:       return 32'(bus.writedata_mgmt_0);
            1:       return 32'(bus.writedata_mgmt_1);
            default: return 32'(bus.writedata_mgmt_2);
        endcase
    endfunction

    // Present one byte; returns at the falling edge before its accepting rising edge.
    task automatic send_byte(input logic [7:0] b, input logic last);
        int waited = 0;
        @(negedge clk);
        bus.c_tvalid = 1'b1;
        bus.c_tdata  = b;
        bus.c_tlast  = last;
        while (bus.c_tready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) begin
            checks++;
            $display("FAIL handshake_timeout: c_tready got %b want 1 after %0d cycles", bus.c_tready, waited);
        end
        last_hs_cyc = cyc;
    endtask

    task automatic send_frame(input bytes_t fr, input bit gaps, output bit good);
        for (int i = 0; i < fr.size(); i++) begin
            if (gaps && i > 0) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    bus.c_tvalid = 1'b0;
                end
            end
            send_byte(fr[i], i == fr.size() - 1);
        end
        model_frame(fr, good);
    endtask

    task automatic settle(input int n);
        @(negedge clk);
        bus.c_tvalid = 1'b0;
        bus.c_tlast  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.c_tvalid = 1'b0;
        bus.c_tlast  = 1'b0;
        bus.c_tdata  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.we_mgmt_0, bus.we_mgmt_1, bus.we_mgmt_2} !== 3'b000)
            $display("FAIL reset_we: got %b want 000", {bus.we_mgmt_0, bus.we_mgmt_1, bus.we_mgmt_2});
        else passes++;
        checks++;
        if ({bus.writedata_mgmt_0, bus.writeaddr_mgmt_0, bus.writedata_mgmt_1, bus.writeaddr_mgmt_1,
             bus.writedata_mgmt_2, bus.writeaddr_mgmt_2} !== '0)
            $display("FAIL reset_ports: got %h/%h %h/%h %h/%h want all 0", bus.writedata_mgmt_0, bus.writeaddr_mgmt_0,
                     bus.writedata_mgmt_1, bus.writeaddr_mgmt_1, bus.writedata_mgmt_2, bus.writeaddr_mgmt_2);
        else passes++;
        checks++;
        if ({bus.cmd_cnt, bus.err_cnt} !== 16'h0000)
            $display("FAIL reset_counters: got cmd %h err %h want 0 0", bus.cmd_cnt, bus.err_cnt);
        else passes++;
        checks++;
        if (bus.c_tready !== 1'b1) $display("FAIL reset_tready: got %b want 1", bus.c_tready);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.c_tready !== 1'b1) $display("FAIL post_reset_tready: got %b want 1", bus.c_tready);
        else passes++;
    endtask

    task automatic test_mgmt0();
        bytes_t fr = '{8'h00, 8'h1F, 8'hFF, 8'h01, 8'hAA};
        bit good;
        int rd = obs_q.size();
        send_frame(fr, 1'b0, good);
        settle(2);
        checks++;
        if (obs_q.size() != rd + 1) $display("FAIL mgmt0_pulse_count: got %0d want 1", obs_q.size() - rd);
        else begin
            passes++;
            checks++;
            if (obs_q[rd].port != 0 || obs_q[rd].addr != 'h1FFF || obs_q[rd].data != 'h1AA)
                $display("FAIL mgmt0_write: got port %0d addr %h data %h want 0 1fff 1aa",
                         obs_q[rd].port, obs_q[rd].addr, obs_q[rd].data);
            else passes++;
            checks++;
            if (obs_q[rd].cyc != last_hs_cyc + 1)
                $display("FAIL mgmt0_latency: got cycle %0d want %0d", obs_q[rd].cyc, last_hs_cyc + 1);
            else passes++;
        end
        checks++;
        if (bus.writeaddr_mgmt_0 !== 13'h1FFF || bus.writedata_mgmt_0 !== 9'h1AA)
            $display("FAIL mgmt0_hold: got %h/%h want 1fff/1aa", bus.writeaddr_mgmt_0, bus.writedata_mgmt_0);
        else passes++;
        checks++;
        if (bus.cmd_cnt !== 8'd1) $display("FAIL mgmt0_cmd_cnt: got %0d want 1", bus.cmd_cnt);
        else passes++;
    endtask

    task automatic test_mgmt2();
        bytes_t fr = '{8'h02, 8'h00, 8'h0C, 8'hBE, 8'hEF};
        bit good;
        int rd = obs_q.size();
        send_frame(fr, 1'b1, good);
        settle(2);
        checks++;
        if (obs_q.size() != rd + 1) $display("FAIL mgmt2_pulse_count: got %0d want 1", obs_q.size() - rd);
        else begin
            passes++;
            checks++;
            if (obs_q[rd].port != 2 || obs_q[rd].addr != 'hC || obs_q[rd].data != 'hBEEF)
                $display("FAIL mgmt2_write: got port %0d addr %h data %h want 2 c beef",
                         obs_q[rd].port, obs_q[rd].addr, obs_q[rd].data);
            else passes++;
        end
        checks++;
        if (bus.writeaddr_mgmt_0 !== 13'h1FFF || bus.writedata_mgmt_0 !== 9'h1AA ||
            bus.writeaddr_mgmt_1 !== 4'h0 || bus.writedata_mgmt_1 !== 16'h0000)
            $display("FAIL mgmt2_others_hold: got %h/%h %h/%h want 1fff/1aa 0/0", bus.writeaddr_mgmt_0,
                     bus.writedata_mgmt_0, bus.writeaddr_mgmt_1, bus.writedata_mgmt_1);
        else passes++;
        checks++;
        if (bus.cmd_cnt !== 8'(exp_cmd)) $display("FAIL mgmt2_cmd_cnt: got %0d want %0d", bus.cmd_cnt, exp_cmd);
        else passes++;
    endtask

    task automatic test_back_to_back();
        bytes_t f1 = '{8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
        bytes_t f2 = '{8'h02, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        bit good;
        int rd = obs_q.size();
        int low0 = ready_low;
        send_frame(f1, 1'b0, good);
        send_frame(f2, 1'b0, good);
        settle(2);
        checks++;
        if (obs_q.size() != rd + 2) $display("FAIL b2b_pulse_count: got %0d want 2", obs_q.size() - rd);
        else begin
            passes++;
            checks++;
            if (obs_q[rd + 1].cyc - obs_q[rd].cyc != 6)
                $display("FAIL b2b_spacing: got %0d want 6", obs_q[rd + 1].cyc - obs_q[rd].cyc);
            else passes++;
            checks++;
            if (obs_q[rd].port != 1 || obs_q[rd].addr != 'h4 || obs_q[rd].data != 'h5678 ||
                obs_q[rd + 1].port != 2 || obs_q[rd + 1].addr != 'hC || obs_q[rd + 1].data != 'hDEF0)
                $display("FAIL b2b_writes: got %0d:%h:%h %0d:%h:%h want 1:4:5678 2:c:def0",
                         obs_q[rd].port, obs_q[rd].addr, obs_q[rd].data,
                         obs_q[rd + 1].port, obs_q[rd + 1].addr, obs_q[rd + 1].data);
            else passes++;
        end
        checks++;
        if (ready_low - low0 != 2) $display("FAIL b2b_tready_low: got %0d cycles want 2", ready_low - low0);
        else passes++;
    endtask

    task automatic test_short();
        bytes_t fs = '{8'h01, 8'h00, 8'h03};
        bytes_t fg = '{8'h00, 8'h01, 8'h23, 8'h01, 8'h45};
        bit good;
        int rd = obs_q.size();
        int e0 = exp_err;
        send_frame(fs, 1'b0, good);
        settle(2);
        checks++;
        if (obs_q.size() != rd || bus.err_cnt !== 8'(e0 + 1))
            $display("FAIL short_frame: got writes %0d err %0d want 0 %0d", obs_q.size() - rd, bus.err_cnt, e0 + 1);
        else passes++;
        send_frame(fg, 1'b0, good);
        settle(2);
        checks++;
        if (obs_q.size() != rd + 1 || bus.writeaddr_mgmt_0 !== 13'h0123 || bus.writedata_mgmt_0 !== 9'h145)
            $display("FAIL short_then_good: got writes %0d %h/%h want 1 0123/145", obs_q.size() - rd,
                     bus.writeaddr_mgmt_0, bus.writedata_mgmt_0);
        else passes++;
    endtask

    task automatic test_long();
        bytes_t fl = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h05, 8'h77, 8'h88};
        bytes_t fg = '{8'h01, 8'h00, 8'h07, 8'hCA, 8'hFE};
        bit good;
        int rd = obs_q.size();
        int e0 = exp_err;
        send_frame(fl, 1'b0, good);
        send_frame(fg, 1'b0, good);
        settle(2);
        checks++;
        if (bus.err_cnt !== 8'(e0 + 1)) $display("FAIL long_err_cnt: got %0d want %0d", bus.err_cnt, e0 + 1);
        else passes++;
        checks++;
        if (obs_q.size() != rd + 1) $display("FAIL long_writes: got %0d want 1", obs_q.size() - rd);
        else begin
            passes++;
            checks++;
            if (obs_q[rd].port != 1 || obs_q[rd].addr != 'h7 || obs_q[rd].data != 'hCAFE)
                $display("FAIL long_then_good: got %0d:%h:%h want 1:7:cafe",
                         obs_q[rd].port, obs_q[rd].addr, obs_q[rd].data);
            else passes++;
        end
    endtask

    task automatic test_bad_sel();
        bytes_t f1 = '{8'h05, 8'h11, 8'h22};
        bytes_t f2 = '{8'h07};
        bytes_t f3 = '{8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        bit good;
        int rd = obs_q.size();
        int e0 = exp_err;
        send_frame(f1, 1'b1, good);
        send_frame(f2, 1'b0, good);
        send_frame(f3, 1'b0, good);
        settle(2);
        checks++;
        if (obs_q.size() != rd || bus.err_cnt !== 8'(e0 + 3))
            $display("FAIL bad_sel: got writes %0d err %0d want 0 %0d", obs_q.size() - rd, bus.err_cnt, e0 + 3);
        else passes++;
    endtask

    task automatic test_reset_mid_frame();
        bytes_t fg = '{8'h01, 8'hAB, 8'hCD, 8'h12, 8'h34};
        bit good;
        int rd;
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h05, 1'b0);
        @(negedge clk);
        bus.c_tvalid = 1'b0;
        rst_n        = 1'b0;
        rd           = obs_q.size();
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.writedata_mgmt_0, bus.writeaddr_mgmt_0, bus.writedata_mgmt_1, bus.writeaddr_mgmt_1,
             bus.writedata_mgmt_2, bus.writeaddr_mgmt_2, bus.cmd_cnt, bus.err_cnt} !== '0)
            $display("FAIL midreset_outputs: got %h/%h %h/%h %h/%h cnt %h %h want all 0", bus.writedata_mgmt_0,
                     bus.writeaddr_mgmt_0, bus.writedata_mgmt_1, bus.writeaddr_mgmt_1, bus.writedata_mgmt_2,
                     bus.writeaddr_mgmt_2, bus.cmd_cnt, bus.err_cnt);
        else passes++;
        checks++;
        if (bus.c_tready !== 1'b1) $display("FAIL midreset_tready: got %b want 1", bus.c_tready);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(fg, 1'b0, good);
        settle(2);
        checks++;
        if (obs_q.size() != rd + 1 || bus.writeaddr_mgmt_1 !== 4'hD || bus.writedata_mgmt_1 !== 16'h1234 ||
            bus.cmd_cnt !== 8'd1 || bus.err_cnt !== 8'd0)
            $display("FAIL midreset_next_frame: got writes %0d %h/%h cnt %0d %0d want 1 d/1234 1 0",
                     obs_q.size() - rd, bus.writeaddr_mgmt_1, bus.writedata_mgmt_1, bus.cmd_cnt, bus.err_cnt);
        else passes++;
    endtask

    task automatic test_random();
        for (int f = 0; f < 60; f++) begin
            bytes_t fr;
            bit good;
            int len;
            int rd;
            len = ($urandom_range(0, 9) < 6) ? 5 : int'($urandom_range(1, 8));
            fr = {};
            for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
            if ($urandom_range(0, 3) != 0) fr[0] = 8'($urandom_range(0, 2));
            rd = obs_q.size();
            send_frame(fr, $urandom_range(0, 1) == 1, good);
            settle(1);
            checks++;
            if (obs_q.size() - rd != (good ? 1 : 0))
                $display("FAIL rand_write_count[%0d]: got %0d want %0d", f, obs_q.size() - rd, good ? 1 : 0);
            else passes++;
            if (good && obs_q.size() == rd + 1) begin
                checks++;
                if (obs_q[rd].port != exp_port || obs_q[rd].addr != exp_addr || obs_q[rd].data != exp_data)
                    $display("FAIL rand_write[%0d]: got %0d:%h:%h want %0d:%h:%h", f, obs_q[rd].port,
                             obs_q[rd].addr, obs_q[rd].data, exp_port, exp_addr, exp_data);
                else passes++;
            end
            for (int p = 0; p < 3; p++) begin
                checks++;
                if (get_wa(p) !== 32'(exp_wa[p]) || get_wd(p) !== 32'(exp_wd[p]))
                    $display("FAIL rand_port_hold[%0d] port %0d: got %h/%h want %h/%h", f, p,
                             get_wa(p), get_wd(p), exp_wa[p], exp_wd[p]);
                else passes++;
            end
            checks++;
            if (bus.cmd_cnt !== 8'(exp_cmd) || bus.err_cnt !== 8'(exp_err))
                $display("FAIL rand_counters[%0d]: got %0d/%0d want %0d/%0d", f, bus.cmd_cnt, bus.err_cnt,
                         exp_cmd, exp_err);
            else passes++;
        end
    endtask

    task automatic test_err_saturation();
        bytes_t fb = '{8'hFF};
        bit good;
        int c0 = exp_cmd;
        for (int i = 0; i < 256; i++) send_frame(fb, 1'b0, good);
        settle(2);
        checks++;
        if (bus.err_cnt !== 8'hFF || exp_err != 255)
            $display("FAIL err_saturation: got %h want ff", bus.err_cnt);
        else passes++;
        checks++;
        if (bus.cmd_cnt !== 8'(c0)) $display("FAIL err_sat_cmd_cnt: got %0d want %0d", bus.cmd_cnt, c0);
        else passes++;
    endtask

    task automatic test_invariants();
        checks++;
        if (ready_bad != 0) $display("FAIL tready_vs_commit: got %0d bad cycles want 0", ready_bad);
        else passes++;
        checks++;
        if (multi_we != 0) $display("FAIL we_onehot: got %0d multi-strobe cycles want 0", multi_we);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_mgmt0();
        test_mgmt2();
        test_back_to_back();
        test_short();
        test_long();
        test_bad_sel();
        test_reset_mid_frame();
        test_random();
        test_err_saturation();
        test_invariants();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
